mod_sub_pipe: RTL and testbench

Pipelined modular subtractor computing s = (a − b) mod M with M = 2^N − k, the inverse operation of the team's combinational modular adder (preprocessing / parallel-prefix / sum-select). Operands enter through a valid/ready handshake and pass through three registered stages: operand preprocessing, prefix carry computation and sum selection. The result is delivered through a valid/ready handshake at a throughput of one operation per cycle. It sits beside the adder in the residue datapath and shares its operand format: N-bit a, b, k.

---
 rtl/mod_sub_pipe.sv | 169 ++++++++++++++++
 tb/tb_mod_sub_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_sub_pipe.sv
// mod_sub_pipe -- pipelined modular subtractor, s = (a - b) mod M, M = 2^N - k.
//
// Three registered stages behind valid/ready handshakes:
//   stage 1 (preprocess): registers a, ~b, k; combinationally forms the
//                         generate/propagate/half-sum vectors of both candidates
//                         and the operand range check.
//   stage 2 (prefix)    : parallel-prefix carries of both candidates, registered
//                         with the half-sums and the range-error flag.
//   stage 3 (select)    : s0 = a - b or s1 = a - b - k (mod 2^N), chosen by the
//                         carry-out of s0; forced to 0 on a range error.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is combinational from out_ready)
//   a, b, k               minuend, subtrahend, modulus offset (N bits each)
//   out_valid / out_ready result handshake
//   s, err                result and operand range-violation flag (stage-3 registers)
module mod_sub_pipe #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         err
);

  // Kogge-Stone prefix network. Returns the carry into every bit position,
  // with carry-in cin feeding bit 0.
  function automatic logic [N-1:0] prefix_carry(input logic [N-1:0] g,
                                                input logic [N-1:0] p,
                                                input logic         cin);
    logic [N-1:0] gg, pp, gn, pn;
    gg = g;
    pp = p;
    for (int d = 1; d < N; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < N; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    return {gg[N-2:0] | (pp[N-2:0] & {(N-1){cin}}), cin};
  endfunction

  // Handshake chain: a stage may load when it is empty or its successor moves.
  logic v1, v2, v3;
  logic ready1, ready2, ready3;

  assign ready3    = ~v3 | out_ready;
  assign ready2    = ~v2 | ready3;
  assign ready1    = ~v1 | ready2;
  assign in_ready  = ready1;
  assign out_valid = v3;

  // Stage 1 registers
  logic [N-1:0] a1, nb1, k1;

  // Stage 1 combinational preprocessing
  logic [N-1:0] h0, g0, h1, g1;
  logic [N-1:0] nk, cs_sum, cs_carry;
  logic [N-2:0] cs_maj;
  logic [N:0]   m_full;
  logic         err1;

  // Stage 2 combinational prefix carries
  logic [N-1:0] ci0, ci1;
  logic         c0;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (here, unconditionally) so no latch can be inferred.
  always_comb begin
    // d0 = a + ~b + 1
    g0 = a1 & nb1;
    h0 = a1 ^ nb1;

    // d1 = a + ~b + ~k + 2: 3:2 carry-save compression of (a, ~b, ~k); one of
    // the two +1s rides in the empty LSB of the shifted carry vector, the other
    // is the adder carry-in.
    nk       = ~k1;
    cs_sum   = a1 ^ nb1 ^ nk;
    cs_maj   = (a1[N-2:0] & nb1[N-2:0]) | (a1[N-2:0] & nk[N-2:0]) |
               (nb1[N-2:0] & nk[N-2:0]);
    cs_carry = {cs_maj, 1'b1};
    g1       = cs_sum & cs_carry;
    h1       = cs_sum ^ cs_carry;

    // Range check against M = 2^N - k (N+1 bits so that k == 0 gives M = 2^N).
    m_full = {1'b1, {N{1'b0}}} - {1'b0, k1};
    err1   = ({1'b0, a1} >= m_full) | ({1'b0, ~nb1} >= m_full) |
             (k1 == '0) | (k1 == {N{1'b1}});

    // Carries of both candidates; c0 = 1 means a >= b.
    ci0 = prefix_carry(g0, h0, 1'b1);
    ci1 = prefix_carry(g1, h1, 1'b1);
    c0  = g0[N-1] | (h0[N-1] & ci0[N-1]);
  end

  // Stage 2 registers
  logic [N-1:0] h0_2, ci0_2, h1_2, ci1_2;
  logic         c0_2, err2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs regardless of statement order.
  // NOTE: data registers are reset along with the valid bits so that no stale
  // operand or result is visible after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      a1    <= '0;
      nb1   <= '0;
      k1    <= '0;
      v2    <= 1'b0;
      h0_2  <= '0;
      ci0_2 <= '0;
      c0_2  <= 1'b0;
      h1_2  <= '0;
      ci1_2 <= '0;
      err2  <= 1'b0;
      v3    <= 1'b0;
      s     <= '0;
      err   <= 1'b0;
    end else begin
      // Stage 1: operands are sampled only on an input transfer.
      if (ready1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1  <= a;
          nb1 <= ~b;
          k1  <= k;
        end
      end

      // Stage 2
      if (ready2) begin
        v2 <= v1;
        if (v1) begin
          h0_2  <= h0;
          ci0_2 <= ci0;
          c0_2  <= c0;
          h1_2  <= h1;
          ci1_2 <= ci1;
          err2  <= err1;
        end
      end

      // Stage 3: a >= b takes s0 directly, otherwise s1 = a - b + M.
      if (ready3) begin
        v3 <= v2;
        if (v2) begin
          err <= err2;
          if (err2)      s <= '0;
          else if (c0_2) s <= h0_2 ^ ci0_2;
          else           s <= h1_2 ^ ci1_2;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Self-checking bench for mod_sub_pipe (N = 7).
// Expected results are produced by an integer reference model when an operand
// transfer is seen and queued; each result transfer pops and compares.
module tb_mod_sub_pipe;

  localparam int N = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a, b, k;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         err;

  mod_sub_pipe #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .k         (k),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_in     = 0;
  int n_out    = 0;
  bit lat_on   = 0;
  bit rand_on  = 0;

  logic [N:0] exp_q[$];  // {err, s}
  int         t_q[$];    // edge index of the input transfer

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                       input logic [N-1:0] tk);
    int ai, bi, ki, m, r;
    logic e;
    ai = int'(ta);
    bi = int'(tb);
    ki = int'(tk);
    m  = 128 - ki;
    e  = (ai >= m) || (bi >= m) || (ki == 0) || (ki == 127);
    r  = e ? 0 : (ai - bi + m) % m;
    return {e, r[N-1:0]};
  endfunction

  // Edge counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor: handshake signals are stable at the falling edge and
  // describe what the next rising edge will transfer.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, k));
        t_q.push_back(cyc + 1);
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(s), 32'hFFFF_FFFF);
        end else begin
          logic [N:0] e;
          int t;
          e = exp_q.pop_front();
          t = t_q.pop_front();
          check("s", 32'(s), 32'(e[N-1:0]));
          check("err", 32'(err), 32'(e[N]));
          if (lat_on) check("latency", 32'(cyc + 1 - t), 32'd3);
        end
      end
    end
  end

  // Random backpressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_on) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Present one operand triple and hold it until it is accepted.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic [N-1:0] tk);
    int  n;
    bit  got;
    n        = 0;
    a        = ta;
    b        = tb;
    k        = tk;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait until every queued result has left the block.
  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        t_q.delete();
      end
    end
  endtask

  initial begin
    logic [N-1:0] bp_a[5];
    logic [N-1:0] bp_b[5];
    int idx;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    k         = '0;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Back-to-back stream, no backpressure: 15, 9, 0, 1 on consecutive edges.
    lat_on = 1;
    send(7'd20, 7'd5,  7'd104);
    send(7'd5,  7'd20, 7'd104);
    send(7'd13, 7'd13, 7'd104);
    send(7'd0,  7'd23, 7'd104);
    drain();
    lat_on = 0;

    // Backpressure: 5 operands offered with out_ready low; 3 fit.
    bp_a = '{7'd10, 7'd3,  7'd23, 7'd0, 7'd12};
    bp_b = '{7'd3,  7'd10, 7'd1,  7'd0, 7'd20};
    out_ready = 1'b0;
    k   = 7'd104;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      a = bp_a[idx]; b = bp_b[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("bp_accepted", 32'(idx), 32'd3);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_s_held", 32'(s), 32'd7);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    while (idx < 5) begin
      a = bp_a[idx]; b = bp_b[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Range violations and boundaries
    send(7'd30, 7'd4,  7'd104);
    send(7'd4,  7'd30, 7'd104);
    send(7'd23, 7'd0,  7'd104);
    send(7'd7,  7'd7,  7'd104);
    send(7'd5,  7'd3,  7'd0);
    send(7'd0,  7'd0,  7'd127);
    send(7'd1,  7'd0,  7'd1);
    send(7'd0,  7'd126,7'd1);
    drain();

    // Reset with operations in flight
    out_ready = 1'b0;
    send(7'd20, 7'd5,  7'd104);
    send(7'd5,  7'd20, 7'd104);
    idle(1);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    t_q.delete();
    idle(2);
    reset     = 1'b0;
    out_ready = 1'b1;
    idle(1);
    lat_on = 1;
    send(7'd1, 7'd2, 7'd104);
    drain();
    lat_on = 0;
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure
    n_in    = 0;
    n_out   = 0;
    rand_on = 1;
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] rk, ra, rb;
      rk = N'($urandom_range(1, 126));
      ra = N'($urandom_range(0, 127 - int'(rk)));
      rb = N'($urandom_range(0, 127 - int'(rk)));
      idle($urandom_range(0, 2));
      send(ra, rb, rk);
    end
    rand_on   = 0;
    out_ready = 1'b1;
    drain();
    idle(2);
    check("rand_count", 32'(n_out), 32'(n_in));
    check("rand_in_count", 32'(n_in), 32'd300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
